// File: rtl/regfile_write_bank_if.sv
// rtl/regfile_write_bank_if.sv - register write request handshake bundle
interface regfile_write_bank_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_bank.sv
// rtl/regfile_write_bank.sv - 16x16 register bank fed by a 2-entry in-order write queue
// Optional REGFILE_BYPASS_EN forwards the youngest queued write onto regs_flat.
module regfile_write_bank #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_write_bank_if.slave    wr,
    input  logic                   hold,
    output logic [DEPTH*WIDTH-1:0] regs_flat,
    output logic [1:0]             pending
);

    logic [ADDR_W-1:0] q_addr_q [2];
    logic [ADDR_W-1:0] q_addr_d [2];
    logic [WIDTH-1:0]  q_data_q [2];
    logic [WIDTH-1:0]  q_data_d [2];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic [WIDTH-1:0]  bank_q [DEPTH];
    logic [WIDTH-1:0]  bank_d [DEPTH];

    logic              accept;
    logic              commit;
    logic [DEPTH*WIDTH-1:0] regs_flat_c;

    // Ready looks only at the registered count, so a full queue refuses even on a commit cycle.
    assign wr.wr_ready = (count_q != 2'd2);
    assign pending     = count_q;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign commit      = !hold && (count_q != 2'd0);

    always_comb begin
        q_addr_d = q_addr_q;
        q_data_d = q_data_q;
        head_d   = head_q;
        tail_d   = tail_q;
        bank_d   = bank_q;
        count_d  = count_q + {1'b0, accept} - {1'b0, commit};
        if (accept) begin
            q_addr_d[tail_q] = wr.wr_addr;
            q_data_d[tail_q] = wr.wr_data;
            tail_d           = ~tail_q;
        end
        if (commit) begin
            head_d = ~head_q;
            if (q_addr_q[head_q] != '0) begin
                bank_d[q_addr_q[head_q]] = q_data_q[head_q];
            end
        end
        bank_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                q_addr_q[i] <= '0;
                q_data_q[i] <= '0;
            end
            for (int k = 0; k < DEPTH; k++) begin
                bank_q[k] <= '0;
            end
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            q_addr_q <= q_addr_d;
            q_data_q <= q_data_d;
            bank_q   <= bank_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Older entry first, younger second, so the youngest matching write wins.
    always_comb begin
        regs_flat_c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [WIDTH-1:0] slot;
            slot = bank_q[k];
            if ((count_q != 2'd0) && (q_addr_q[head_q] == ADDR_W'(k))) begin
                slot = q_data_q[head_q];
            end
            if ((count_q == 2'd2) && (q_addr_q[~head_q] == ADDR_W'(k))) begin
                slot = q_data_q[~head_q];
            end
            if (k == 0) begin
                slot = '0;
            end
            regs_flat_c[k*WIDTH +: WIDTH] = slot;
        end
    end
`else
    always_comb begin
        regs_flat_c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            regs_flat_c[k*WIDTH +: WIDTH] = (k == 0) ? '0 : bank_q[k];
        end
    end
`endif

    assign regs_flat = regs_flat_c;

endmodule
